// File: rtl/rab_uart_pkg.sv
// Shared RAB and UART constants: bus widths, register offsets, STATUS bit
// positions and the TX/RX state encodings.
package rab_uart_pkg;

  localparam int RAB_ADDR_WIDTH = 8;
  localparam int RAB_DATA_WIDTH = 8;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV_LO = 3'd2;
  localparam logic [2:0] REG_DIV_HI = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int ST_RX_NEMPTY  = 0;
  localparam int ST_RX_FULL    = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_HOLD_FULL  = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_FRAME_ERR  = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/rab_uart_sync_fifo.sv
// Byte-wide synchronous FIFO for received UART data; a push into a full FIFO
// succeeds only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rab_uart.sv
// RAB-mapped 8N1 UART: register decode and ack, TX holding register plus
// shifter, RX sampler feeding a small FIFO, sticky error flags and an IRQ.
module rab_uart
  import rab_uart_pkg::*;
#(
  parameter int          RX_FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET     = 16'd433
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [4:0]                baseaddr,
  input  logic                      rab_write,
  input  logic                      rab_read,
  input  logic [RAB_ADDR_WIDTH-1:0] rab_addr,
  input  logic [RAB_DATA_WIDTH-1:0] rab_wdata,
  output logic                      rab_ack,
  output logic [RAB_DATA_WIDTH-1:0] rab_rdata,
  input  logic                      uart_rxd,
  output logic                      uart_txd,
  output logic                      uart_irq
);

  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        irq_q, irq_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_sync_q, rx_sync_d;

  logic        acc, wr, rd, fifo_push, fifo_pop, fifo_full, fifo_empty, rx_line, rx_fall;
  logic [2:0]  off;
  logic [7:0]  fifo_dout, status;
  logic [15:0] div_eff, half;

  uart_sync_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_clk), .rst(sys_rst), .push(fifo_push), .din(rx_shift_q),
    .pop(fifo_pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );

  // A request is serviced once; the held request in the ack cycle is ignored.
  assign acc      = (rab_addr[7:3] == baseaddr) && (rab_write || rab_read) && !ack_q;
  assign wr       = acc && rab_write;
  assign rd       = acc && rab_read;
  assign off      = rab_addr[2:0];
  assign fifo_pop = rd && (off == REG_DATA) && !fifo_empty;
  assign div_eff  = (div_q < 16'd3) ? 16'd3 : div_q;
  assign half     = {1'b0, div_eff[15:1]} + {15'd0, div_eff[0]};
  assign rx_line  = rx_sync_q[1];
  assign rx_fall  = rx_sync_q[2] && !rx_sync_q[1];

  assign uart_txd  = (tx_state_q == TX_START) ? 1'b0 :
                     (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
  assign rab_ack   = ack_q;
  assign rab_rdata = rdata_q;
  assign uart_irq  = irq_q;

  always_comb begin
    status               = '0;
    status[ST_RX_NEMPTY] = !fifo_empty;
    status[ST_RX_FULL]   = fifo_full;
    status[ST_TX_BUSY]   = (tx_state_q != TX_IDLE);
    status[ST_HOLD_FULL] = hold_full_q;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = frame_err_q;
  end

  always_comb begin
    ack_d       = acc;
    rdata_d     = '0;
    div_d       = div_q;
    ctrl_d      = ctrl_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_sync_d   = {rx_sync_q[1:0], ctrl_q[2] ? uart_txd : uart_rxd};
    fifo_push   = 1'b0;
    irq_d       = !fifo_empty || overrun_q;

    if (rd) begin
      case (off)
        REG_DATA:   rdata_d = fifo_empty ? 8'h00 : fifo_dout;
        REG_STATUS: rdata_d = status;
        REG_DIV_LO: rdata_d = div_q[7:0];
        REG_DIV_HI: rdata_d = div_q[15:8];
        REG_CTRL:   rdata_d = {5'd0, ctrl_q};
        default:    rdata_d = 8'h00;
      endcase
    end

    if (wr) begin
      case (off)
        REG_DATA: if (!hold_full_q) begin
          hold_d      = rab_wdata;
          hold_full_d = 1'b1;
        end
        REG_STATUS: begin
          if (rab_wdata[ST_OVERRUN])   overrun_d   = 1'b0;
          if (rab_wdata[ST_FRAME_ERR]) frame_err_d = 1'b0;
        end
        REG_DIV_LO: div_d[7:0]  = rab_wdata;
        REG_DIV_HI: div_d[15:8] = rab_wdata;
        REG_CTRL:   ctrl_d      = rab_wdata[2:0];
        default: ;
      endcase
    end

    // TX: each state spans div_eff+1 cycles; STOP chains straight into START.
    case (tx_state_q)
      TX_IDLE: if (hold_full_q && ctrl_q[0]) begin
        tx_shift_d = hold_q; hold_full_d = 1'b0; tx_cnt_d = '0; tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q >= div_eff) begin
        tx_cnt_d = '0; tx_bit_d = '0; tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      TX_DATA: if (tx_cnt_q >= div_eff) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      TX_STOP: if (tx_cnt_q >= div_eff) begin
        tx_cnt_d = '0;
        if (hold_full_q && ctrl_q[0]) begin
          tx_shift_d = hold_q; hold_full_d = 1'b0; tx_state_d = TX_START;
        end else tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      default: tx_state_d = TX_IDLE;
    endcase

    // RX: error flags are set after the register write so a set beats a clear.
    case (rx_state_q)
      RX_IDLE: if (ctrl_q[1] && rx_fall) begin
        rx_cnt_d = '0; rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q >= half) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_state_d = rx_line ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_DATA: if (rx_cnt_q >= div_eff) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_line, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_STOP: if (rx_cnt_q >= div_eff) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        if (!rx_line)                    frame_err_d = 1'b1;
        else if (fifo_full && !fifo_pop) overrun_d   = 1'b1;
        else                             fifo_push   = 1'b1;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      div_q       <= DIV_RESET;
      ctrl_q      <= 3'b011;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_sync_q   <= 3'b111;
    end else begin
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      div_q       <= div_d;
      ctrl_q      <= ctrl_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_sync_q   <= rx_sync_d;
    end
  end

endmodule

// File: tb/tb_rab_uart.sv
// Directed bench for rab_uart: register access, TX waveforms, loopback,
// overrun, frame error, start-bit glitch, decode and mid-frame reset.
module tb_rab_uart;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [4:0] baseaddr;
  logic       rab_write, rab_read;
  logic [7:0] rab_addr, rab_wdata;
  logic       rab_ack;
  logic [7:0] rab_rdata;
  logic       uart_rxd, uart_txd, uart_irq;

  int checks = 0;
  int errors = 0;

  logic rec [256];
  int   rec_n = 0;
  logic rec_en = 1'b0;

  rab_uart dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .baseaddr(baseaddr),
    .rab_write(rab_write), .rab_read(rab_read), .rab_addr(rab_addr),
    .rab_wdata(rab_wdata), .rab_ack(rab_ack), .rab_rdata(rab_rdata),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd), .uart_irq(uart_irq)
  );

  always #5 sys_clk = ~sys_clk;

  // Captures uart_txd once per cycle, 2 time units after the rising edge.
  always @(posedge sys_clk) begin
    #2;
    if (!rec_en) rec_n = 0;
    else if (rec_n < 256) begin
      rec[rec_n] = uart_txd;
      rec_n = rec_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rab_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge sys_clk);
    rab_write = 1'b1; rab_addr = a; rab_wdata = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (rab_ack) break;
    end
    rab_write = 1'b0;
  endtask

  task automatic rab_rd(input logic [7:0] a, output logic [7:0] d, output logic ok);
    ok = 1'b0; d = '0;
    @(negedge sys_clk);
    rab_read = 1'b1; rab_addr = a;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (rab_ack) begin ok = 1'b1; d = rab_rdata; break; end
    end
    rab_read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic ok;
    rab_rd(a, d, ok);
    check({tag, "_ack"}, {15'd0, ok}, 16'd1);
    check(tag, {8'd0, d}, {8'd0, exp});
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v, input int bitlen);
    @(negedge sys_clk);
    uart_rxd = 1'b0;
    repeat (bitlen) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (bitlen) @(negedge sys_clk);
    end
    uart_rxd = stop_v;
    repeat (bitlen) @(negedge sys_clk);
    uart_rxd = 1'b1;
    repeat (bitlen) @(negedge sys_clk);
  endtask

  // Expected txd for cycle k of a frame with 4-cycle bits (DIV=3).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k < 4) return 1'b0;
    else if (k < 36) return b[(k - 4) / 4];
    else return 1'b1;
  endfunction

  initial begin
    logic [7:0] d;
    logic ok;
    sys_rst = 1'b1; baseaddr = 5'h03;
    rab_write = 1'b0; rab_read = 1'b0; rab_addr = '0; rab_wdata = '0;
    uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_txd", {15'd0, uart_txd}, 16'd1);
    check("rst_ack", {15'd0, rab_ack}, 16'd0);
    check("rst_rdata", {8'd0, rab_rdata}, 16'd0);
    check("rst_irq", {15'd0, uart_irq}, 16'd0);

    // Decode and reset register values.
    rab_rd(8'h10, d, ok);
    check("decode_miss_ack", {15'd0, ok}, 16'd0);
    rd_chk("rst_div_lo", 8'h1A, 8'hB1);
    rd_chk("rst_div_hi", 8'h1B, 8'h01);
    rd_chk("rst_ctrl", 8'h1C, 8'h03);
    rd_chk("rst_status", 8'h19, 8'h00);
    rd_chk("reserved_rd", 8'h1D, 8'h00);
    rd_chk("empty_data", 8'h18, 8'h00);

    // Single TX frame, DIV=3.
    rab_wr(8'h1A, 8'h03);
    rab_wr(8'h1B, 8'h00);
    rd_chk("div_lo3", 8'h1A, 8'h03);
    rab_wr(8'h18, 8'hA5);
    rec_en = 1'b1;
    rd_chk("tx_busy", 8'h19, 8'h04);
    repeat (45) @(negedge sys_clk);
    rec_en = 1'b0;
    check("rec_len_a5", {15'd0, rec_n >= 44}, 16'd1);
    for (int k = 0; k < 44; k++)
      check($sformatf("txa5_%0d", k), {15'd0, rec[k]}, {15'd0, exp_bit(8'hA5, k)});
    rd_chk("tx_done", 8'h19, 8'h00);

    // Back-to-back TX; third write dropped while hold is full.
    rab_wr(8'h18, 8'h55);
    rec_en = 1'b1;
    rab_wr(8'h18, 8'h0F);
    rab_wr(8'h18, 8'h77);
    rd_chk("hold_full", 8'h19, 8'h0C);
    repeat (125) @(negedge sys_clk);
    rec_en = 1'b0;
    check("rec_len_b2b", {15'd0, rec_n >= 120}, 16'd1);
    for (int k = 0; k < 120; k++) begin
      logic e;
      if (k < 40) e = exp_bit(8'h55, k);
      else if (k < 80) e = exp_bit(8'h0F, k - 40);
      else e = 1'b1;
      check($sformatf("b2b_%0d", k), {15'd0, rec[k]}, {15'd0, e});
    end

    // Loopback.
    rab_wr(8'h1C, 8'h07);
    rab_wr(8'h18, 8'h3C);
    repeat (60) @(negedge sys_clk);
    check("lb_irq", {15'd0, uart_irq}, 16'd1);
    rd_chk("lb_status", 8'h19, 8'h01);
    rd_chk("lb_data", 8'h18, 8'h3C);
    rd_chk("lb_status2", 8'h19, 8'h00);
    repeat (2) @(negedge sys_clk);
    check("lb_irq_clr", {15'd0, uart_irq}, 16'd0);
    rab_wr(8'h1C, 8'h03);

    // Overrun: five frames into a four-entry FIFO.
    for (int v = 1; v <= 5; v++) send_rx(v[7:0], 1'b1, 4);
    repeat (10) @(negedge sys_clk);
    rd_chk("ovr_status", 8'h19, 8'h13);
    check("ovr_irq", {15'd0, uart_irq}, 16'd1);
    for (int v = 1; v <= 4; v++) rd_chk($sformatf("ovr_data%0d", v), 8'h18, v[7:0]);
    rd_chk("ovr_empty", 8'h18, 8'h00);
    rd_chk("ovr_status2", 8'h19, 8'h10);
    rab_wr(8'h19, 8'h10);
    rd_chk("ovr_cleared", 8'h19, 8'h00);

    // Frame error: stop bit 0.
    send_rx(8'hAA, 1'b0, 4);
    repeat (10) @(negedge sys_clk);
    rd_chk("ferr_status", 8'h19, 8'h20);
    check("ferr_irq", {15'd0, uart_irq}, 16'd0);
    rab_wr(8'h19, 8'h20);
    rd_chk("ferr_cleared", 8'h19, 8'h00);

    // One-cycle glitch with DIV=7.
    rab_wr(8'h1A, 8'h07);
    @(negedge sys_clk);
    uart_rxd = 1'b0;
    @(negedge sys_clk);
    uart_rxd = 1'b1;
    repeat (100) @(negedge sys_clk);
    rd_chk("glitch_status", 8'h19, 8'h00);
    check("glitch_irq", {15'd0, uart_irq}, 16'd0);

    // Reset in the middle of a TX frame.
    rab_wr(8'h1A, 8'h03);
    rab_wr(8'h18, 8'h00);
    repeat (10) @(negedge sys_clk);
    check("midtx_low", {15'd0, uart_txd}, 16'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_txd", {15'd0, uart_txd}, 16'd1);
    check("rst_mid_ack", {15'd0, rab_ack}, 16'd0);
    check("rst_mid_irq", {15'd0, uart_irq}, 16'd0);
    sys_rst = 1'b0;
    rd_chk("rst2_div_lo", 8'h1A, 8'hB1);
    rd_chk("rst2_div_hi", 8'h1B, 8'h01);
    rd_chk("rst2_ctrl", 8'h1C, 8'h03);
    rd_chk("rst2_status", 8'h19, 8'h00);
    check("rst2_txd", {15'd0, uart_txd}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rab_uart.md
# rab_uart

RAB-mapped 8N1 UART responder that forms the far end of the MCU serial port (mcu_txd0 / mcu_rxd0i), or talks to any external UART, under register control from the I2C slave or the MCU through the arbiter. It sits on the shared RAB beside hq_reg_file and i2cm_top. It decodes its own base address, and it acks only its own window.

## Interface
- RX_FIFO_DEPTH, 4: receive FIFO entries; must be a power of 2, minimum 2.
- DIV_RESET, 16'd433: divisor reset value (bit period = DIV+1 sys_clk cycles).
- RAB_ADDR_WIDTH / RAB_DATA_WIDTH: taken from the global parameter file; fixed at 8 / 8.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  synchronous, active-high reset.
- baseaddr  in  5  matched against rab_addr[7:3].
- rab_write  in  1  write request, held until ack.
- rab_read  in  1  read request, held until ack.
- rab_addr  in  8  register address.
- rab_wdata  in  8  write data.
- rab_ack  out  1  one-cycle acknowledge.
- rab_rdata  out  8  read data, valid while rab_ack=1.
- uart_rxd  in  1  asynchronous serial input.
- uart_txd  out  1  serial output, idle high.
- uart_irq  out  1  registered (RX FIFO non-empty) OR overrun flag.

## Operation
- Decode: the block is hit when rab_addr[7:3]==baseaddr. Requests outside the window are never acked.
- Register map, selected by rab_addr[2:0]:
  - 0 DATA. A write loads the TX holding register. A read pops the RX FIFO; reading an empty FIFO returns 0 and does not pop.
  - 1 STATUS. Bit 0 rx_nempty, bit 1 rx_full, bit 2 tx_busy (shifter active), bit 3 hold_full, bit 4 overrun (sticky), bit 5 frame_err (sticky). Writing 1 to bit 4 or bit 5 clears that bit. Other bits are read-only.
  - 2 DIV_LO, 3 DIV_HI. Together they form the 16-bit divisor. Values below 3 are clamped to 3.
  - 4 CTRL. Bit 0 tx_en, bit 1 rx_en, bit 2 loopback (RX input = uart_txd; uart_txd itself keeps driving).
  - 5–7 read 0; writes to them are ignored, but still acked.
- TX FSM, states IDLE → START → DATA(8, LSB first) → STOP → IDLE:
  - Each state lasts DIV+1 cycles.
  - It leaves IDLE when hold_full && tx_en, transferring hold into the shifter and clearing hold_full.
  - At the end of STOP, if hold_full, it goes directly to START with no idle gap.
  - A DATA write while hold_full is dropped, but still acked.
- RX FSM, states IDLE → START → DATA → STOP:
  - uart_rxd passes through a 2-flop synchroniser.
  - A falling edge in IDLE while rx_en starts reception.
  - Start-bit check at (DIV+1)>>1 cycles: if the line is high, return to IDLE (glitch). Otherwise sample every DIV+1 cycles, 8 data bits, then the stop bit.
  - Stop bit = 0: set frame_err and discard the byte.
  - Stop bit = 1 with the FIFO full and no same-cycle pop: set overrun and discard the byte. Otherwise push.
- DIV and CTRL changes take effect immediately. A frame in progress may be corrupted; software changes them only when idle.

## Timing
- Ack: rab_ack pulses 1 cycle, in the cycle after a request is first seen. It is not re-issued while the request stays high in the cycle immediately following the ack. Reads register rab_rdata together with ack, and the pop occurs on the ack cycle.
- TX latency: the ack cycle of the DATA write, then uart_txd falls 1 cycle later (shifter idle, tx_en=1).
- RX latency: rx_nempty rises 2 (synchroniser) + 1 cycles after the stop-bit sample.
- Push and pop in the same cycle with the FIFO full: both succeed and overrun is not set. With the FIFO empty: the pushed byte remains.
- Reset values:
  - uart_txd=1, rab_ack=0, rab_rdata=0, uart_irq=0.
  - DIV=DIV_RESET, CTRL=3'b011.
  - FIFO empty, flags 0, both FSMs IDLE.
- Reset mid-frame: uart_txd is high in the cycle after sys_rst is sampled, and the partial RX byte is lost.

## Structure
- The register offsets (0–4), STATUS bit indices, and FSM state encodings go in the shared global parameter file beside RAB_ADDR_WIDTH.
- One sub-module, uart_sync_fifo: parameterised depth, 8-bit data, push/pop/full/empty, one-clock sync reset. All other logic stays in rab_uart.

## Test plan
- TX: DIV=3, write 0xA5 to DATA. Expect uart_txd to hold 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. tx_busy is high throughout.
- Back-to-back TX: write 0x55, then 0x0F while the first is shifting. Expect the second start bit immediately after the first stop bit. A third write while hold_full is dropped (only 2 frames appear).
- Loopback RX: CTRL=3'b111, send 0x3C. Expect STATUS=0x01 and DATA read=0x3C. After the read, STATUS=0x00 and uart_irq=0.
- Overrun: inject 5 frames (0x01–0x05) without reading. Expect rx_full, overrun=1, reads 0x01–0x04, then 0. Write 0x10 to STATUS: overrun clears.
- Frame error / glitch:
  - Drive a frame with stop bit 0: frame_err=1, FIFO stays empty.
  - Drive a 1-cycle low pulse with DIV=7: no reception, no flags.
- Decode / reset:
  - With baseaddr=5'h3, a read at 0x10 gets no ack. A read at 0x1A gets ack with 0xB1 (DIV_LO reset).
  - Assert sys_rst mid-TX: uart_txd=1 next cycle and all registers at reset values.
